// File: rtl/jt89_noise_if.sv
// Control/data bundle for the noise channel: register write strobes,
// rate enables and the registered amplitude returned to the mixer.
interface jt89_noise_if;
    logic       clk_en;
    logic       wr_ctrl;
    logic [2:0] ctrl_din;
    logic       wr_vol;
    logic [3:0] vol_din;
    logic       tone2_tick;
    logic [8:0] noise;

    modport master (
        output clk_en, wr_ctrl, ctrl_din, wr_vol, vol_din, tone2_tick,
        input  noise
    );

    modport slave (
        input  clk_en, wr_ctrl, ctrl_din, wr_vol, vol_din, tone2_tick,
        output noise
    );
endinterface

// File: rtl/jt89_noise.sv
// SN76489-style noise channel: 15-bit LFSR clocked by a selectable rate
// divider or by tone channel 2, scaled through a 2 dB/step attenuator.
module jt89_noise (
    input  logic              clk,
    input  logic              rst,
    jt89_noise_if.slave       bus
);
    localparam logic [14:0] LFSR_SEED = 15'h4000;

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [3:0]  vol_q,   vol_d;
    logic [14:0] lfsr_q,  lfsr_d;
    logic [6:0]  cnt_q,   cnt_d;
    logic [8:0]  noise_q, noise_d;

    logic [8:0]  amp;
    logic        rate_hit;
    logic        shift_evt;
    logic        fb_bit;

    always_comb begin
        amp = 9'd0;
        case (vol_q)
            4'd0:    amp = 9'd511;
            4'd1:    amp = 9'd406;
            4'd2:    amp = 9'd322;
            4'd3:    amp = 9'd256;
            4'd4:    amp = 9'd203;
            4'd5:    amp = 9'd162;
            4'd6:    amp = 9'd128;
            4'd7:    amp = 9'd102;
            4'd8:    amp = 9'd81;
            4'd9:    amp = 9'd64;
            4'd10:   amp = 9'd51;
            4'd11:   amp = 9'd41;
            4'd12:   amp = 9'd32;
            4'd13:   amp = 9'd26;
            4'd14:   amp = 9'd20;
            default: amp = 9'd0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        vol_d    = vol_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        rate_hit = 1'b0;

        case (ctrl_q[1:0])
            2'd0:    rate_hit = (cnt_q[4:0] == 5'd31);
            2'd1:    rate_hit = (cnt_q[5:0] == 6'd63);
            2'd2:    rate_hit = (cnt_q == 7'd127);
            default: rate_hit = 1'b0;
        endcase

        // NF=3 hands the shift clock to tone channel 2; the divider still runs.
        shift_evt = (ctrl_q[1:0] == 2'd3) ? bus.tone2_tick
                                          : (bus.clk_en & rate_hit);
        fb_bit    = ctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[1]) : lfsr_q[0];

        if (bus.clk_en) begin
            cnt_d = cnt_q + 7'd1;
        end
        if (shift_evt) begin
            lfsr_d = {fb_bit, lfsr_q[14:1]};
        end

        // A control write always reseeds, even over a coincident shift.
        if (bus.wr_ctrl) begin
            ctrl_d = bus.ctrl_din;
            lfsr_d = LFSR_SEED;
            cnt_d  = 7'd0;
        end
        if (bus.wr_vol) begin
            vol_d = bus.vol_din;
        end

        noise_d = lfsr_q[0] ? amp : 9'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= 3'b000;
            vol_q   <= 4'hF;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= 7'd0;
            noise_q <= 9'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            vol_q   <= vol_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            noise_q <= noise_d;
        end
    end

    assign bus.noise = noise_q;
endmodule

// File: tb/tb_jt89_noise.sv
// Directed bench for jt89_noise: reset, periodic/white sequences, tone2
// clocking, attenuation table and write/shift collision.
module tb_jt89_noise;
    logic clk = 1'b0;
    logic rst = 1'b0;

    jt89_noise_if bus_if ();

    jt89_noise u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int amp_tbl [16] = '{511, 406, 322, 256, 203, 162, 128, 102,
                         81, 64, 51, 41, 32, 26, 20, 0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic write_ctrl(input logic [2:0] v);
        bus_if.ctrl_din = v;
        bus_if.wr_ctrl  = 1'b1;
        @(negedge clk);
        bus_if.wr_ctrl  = 1'b0;
    endtask

    task automatic write_vol(input logic [3:0] v);
        bus_if.vol_din = v;
        bus_if.wr_vol  = 1'b1;
        @(negedge clk);
        bus_if.wr_vol  = 1'b0;
    endtask

    task automatic pulse_tick();
        bus_if.tone2_tick = 1'b1;
        @(negedge clk);
        bus_if.tone2_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ones;
        int n;

        bus_if.clk_en     = 1'b0;
        bus_if.wr_ctrl    = 1'b0;
        bus_if.ctrl_din   = 3'b000;
        bus_if.wr_vol     = 1'b0;
        bus_if.vol_din    = 4'h0;
        bus_if.tone2_tick = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_noise", int'(bus_if.noise), 0);
        rst = 1'b1;
        @(negedge clk);

        // Periodic, NF=0, full volume: 32 high cycles every 480.
        bus_if.clk_en = 1'b1;
        write_vol(4'h0);
        write_ctrl(3'b000);
        ones = 0;
        for (int m = 1; m <= 960; m++) begin
            @(negedge clk);
            if (bus_if.noise == 9'd511) ones++;
            if (m == 448) check_eq("periodic_e448", int'(bus_if.noise), 0);
            if (m == 449) check_eq("periodic_e449", int'(bus_if.noise), 511);
            if (m == 480) check_eq("periodic_e480", int'(bus_if.noise), 511);
            if (m == 481) check_eq("periodic_e481", int'(bus_if.noise), 0);
            if (m == 929) check_eq("periodic_e929", int'(bus_if.noise), 511);
        end
        check_eq("periodic_ones_960", ones, 64);

        // Control write on the very edge of a shift event.
        write_ctrl(3'b000);
        repeat (31) @(negedge clk);
        write_ctrl(3'b000);
        for (int m = 1; m <= 449; m++) begin
            @(negedge clk);
            if (m == 417) check_eq("collide_e417", int'(bus_if.noise), 0);
            if (m == 448) check_eq("collide_e448", int'(bus_if.noise), 0);
            if (m == 449) check_eq("collide_e449", int'(bus_if.noise), 511);
        end

        // tone2 ticks are ignored outside NF=3.
        bus_if.clk_en = 1'b0;
        write_ctrl(3'b001);
        repeat (14) pulse_tick();
        check_eq("nf1_ticks_ignored", int'(bus_if.noise), 0);

        // NF=3: each tick is one shift, with clk_en low.
        write_ctrl(3'b011);
        repeat (10) pulse_tick();
        check_eq("nf3_after10", int'(bus_if.noise), 0);
        repeat (3) pulse_tick();
        check_eq("nf3_after13", int'(bus_if.noise), 0);
        pulse_tick();
        check_eq("nf3_after14", int'(bus_if.noise), 511);

        // Attenuation sweep with lfsr[0] held high.
        for (int v = 0; v < 16; v++) begin
            bus_if.vol_din = 4'(v);
            bus_if.wr_vol  = 1'b1;
            @(negedge clk);
            bus_if.wr_vol  = 1'b0;
            if (v == 4) check_eq("vol_latency", int'(bus_if.noise), amp_tbl[3]);
            @(negedge clk);
            check_eq($sformatf("vol_sweep_%0d", v), int'(bus_if.noise), amp_tbl[v]);
        end
        write_vol(4'h0);
        @(negedge clk);
        check_eq("vol_restore", int'(bus_if.noise), 511);

        // Mid-cycle reset, strobes during reset must be discarded.
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_noise", int'(bus_if.noise), 0);
        @(negedge clk);
        bus_if.clk_en   = 1'b1;
        bus_if.ctrl_din = 3'b011;
        bus_if.wr_ctrl  = 1'b1;
        bus_if.vol_din  = 4'h0;
        bus_if.wr_vol   = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.wr_ctrl  = 1'b0;
        bus_if.wr_vol   = 1'b0;
        rst = 1'b1;
        ones = 0;
        for (int m = 1; m <= 470; m++) begin
            @(negedge clk);
            if (bus_if.noise != 9'd0) ones++;
            if (m == 449) check_eq("post_reset_volF", int'(bus_if.noise), 0);
        end
        check_eq("post_reset_silent", ones, 0);
        write_vol(4'h0);
        @(negedge clk);
        check_eq("post_reset_seed_phase", int'(bus_if.noise), 511);

        // White noise over a full period, clocked from tone2 every cycle.
        bus_if.clk_en = 1'b0;
        write_ctrl(3'b111);
        bus_if.tone2_tick = 1'b1;
        ones = 0;
        n = 32767;
        for (int m = 1; m <= n + 15; m++) begin
            @(negedge clk);
            if (m <= n && bus_if.noise == 9'd511) ones++;
            if (m == 14)     check_eq("white_e14", int'(bus_if.noise), 0);
            if (m == 15)     check_eq("white_e15", int'(bus_if.noise), 511);
            if (m == n + 14) check_eq("white_wrap_e14", int'(bus_if.noise), 0);
            if (m == n + 15) check_eq("white_wrap_e15", int'(bus_if.noise), 511);
        end
        bus_if.tone2_tick = 1'b0;
        check_eq("white_ones_period", ones, 16384);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jt89_noise.md
JT89_NOISE -- requirements
Module: jt89_noise

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous active-low reset; low forces every register to its reset value immediately, release sampled on clk.
REQ-003 clk_en  input  1  chip-rate enable (master/16); shift-rate counter advances only when high.
REQ-004 wr_ctrl  input  1  single-cycle write strobe for noise control register; not gated by clk_en.
REQ-005 ctrl_din  input  3  bit 2 = FB (1 white, 0 periodic); bits 1:0 = NF shift-rate select.
REQ-006 wr_vol  input  1  single-cycle write strobe for attenuation register; not gated by clk_en.
REQ-007 vol_din  input  4  attenuation, 2 dB per step, 4'hF = off.
REQ-008 tone2_tick  input  1  one-cycle pulse when tone channel 2 output toggles; used only when NF=3.
REQ-009 noise  output  9  unsigned channel amplitude, registered, feeds the mixer noise input.

Function
REQ-010 Registers: ctrl[2:0], vol[3:0], lfsr[14:0], rate counter cnt[6:0], output reg noise[8:0].
REQ-011 Rate: on clk_en=1, cnt increments mod 128; shift event when (NF=0 and cnt[4:0]=31), (NF=1 and cnt[5:0]=63), (NF=2 and cnt=127); i.e. one shift per 32/64/128 enabled cycles.
REQ-012 NF=3: shift event on every tone2_tick=1, regardless of clk_en; cnt keeps counting but produces no event.
REQ-013 LFSR shift: lfsr <= {fb_bit, lfsr[14:1]}; fb_bit = lfsr[0]^lfsr[1] when FB=1, lfsr[0] when FB=0.
REQ-014 Periodic mode with seed 15'h4000 gives output bit lfsr[0] high once every 15 shifts.
REQ-015 wr_ctrl=1: ctrl <= ctrl_din, lfsr <= 15'h4000, cnt <= 0, on that edge.
REQ-016 wr_ctrl and a shift event in the same cycle: write wins; no shift applied.
REQ-017 wr_vol=1: vol <= vol_din; LFSR and cnt unaffected.
REQ-018 Attenuation table (vol -> amp): 0:511 1:406 2:322 3:256 4:203 5:162 6:128 7:102 8:81 9:64 10:51 11:41 12:32 13:26 14:20 15:0.
REQ-019 Output: every clk, noise <= lfsr[0] ? amp(vol) : 9'd0, using register values before the current edge; one-cycle latency from any register change to noise.
REQ-020 noise never exceeds 511, so four channels sum within 11 bits unsigned.
REQ-021 Writing ctrl with the same value still reseeds lfsr and clears cnt.
REQ-022 tone2_tick while NF!=3 is ignored.

Reset
REQ-023 rst low: ctrl=3'b000, vol=4'hF, lfsr=15'h4000, cnt=0, noise=0, asynchronously, including mid-shift or mid-write.
REQ-024 Strobes asserted while rst low are discarded; first write accepted on first edge with rst high.

Verification
REQ-025 Reset then hold: rst low mid-run -> noise=0 immediately, lfsr=15'h4000, vol=F observed after release.
REQ-026 Periodic NF=0, vol=0, clk_en always 1: noise=511 for exactly 1 of every 15 shift periods (each 32 cycles), else 0; period 480 cycles.
REQ-027 White NF=2, FB=1: after 32767 shifts (each 128 enabled cycles) lfsr returns to 15'h4000; no all-zero state reached.
REQ-028 NF=3: 10 tone2_tick pulses with clk_en=0 -> exactly 10 shifts; with NF=1, same pulses -> no shift.
REQ-029 Volume sweep: lfsr[0]=1 held, write vol 0..15 -> noise follows REQ-018 table one cycle after each write; vol=F -> 0.
REQ-030 Collision: wr_ctrl in cycle with shift event -> lfsr=15'h4000 and cnt=0 next cycle, no shift.
